// File: rtl/pragmatic_term_scheduler.sv
// Term scheduler for a bit-pragmatic MAC: walks each lane's set weight bits, lowest first,
// and issues the per-lane and shared shifter controls for every weight vector of a tile.
module pragmatic_term_scheduler #(
    parameter int unsigned VEC_LENGTH = 16,
    parameter int unsigned MAG_WIDTH  = 7,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic [CNT_WIDTH-1:0]                  cfg_num_vec_i,
    input  logic                                  w_valid_i,
    output logic                                  w_ready_o,
    input  logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0]  w_mag_i,
    input  logic [VEC_LENGTH-1:0]                 w_sign_i,
    output logic                                  mac_en_o,
    output logic                                  load_accum_o,
    output logic [VEC_LENGTH-1:0][1:0]            shift_1st_sel_o,
    output logic [VEC_LENGTH-1:0]                 shift_1st_en_o,
    output logic [VEC_LENGTH-1:0]                 is_neg_o,
    output logic [1:0]                            shift_2nd_sel_o,
    output logic                                  shift_2nd_en_o,
    output logic                                  vec_done_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int unsigned POS_W = (MAG_WIDTH > 2) ? $clog2(MAG_WIDTH) : 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]                           state_q, state_d;
    logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;
    logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0] mask_q, mask_d;
    logic [VEC_LENGTH-1:0]                sign_q, sign_d;
    logic                                 first_q, first_d;

    logic                                 w_ready_q, w_ready_d;
    logic                                 mac_en_q, mac_en_d;
    logic                                 load_accum_q, load_accum_d;
    logic [VEC_LENGTH-1:0][1:0]           sel1_q, sel1_d;
    logic [VEC_LENGTH-1:0]                en1_q, en1_d;
    logic [VEC_LENGTH-1:0]                neg_q, neg_d;
    logic [1:0]                           sel2_q, sel2_d;
    logic                                 en2_q, en2_d;
    logic                                 vec_done_q, vec_done_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;

    logic                                 xfer;
    logic                                 issue_nx;
    logic                                 any_bits;
    logic                                 all_clear;
    logic [VEC_LENGTH-1:0]                nonempty;
    logic [VEC_LENGTH-1:0][POS_W-1:0]     pos;
    logic [POS_W-1:0]                     min_pos;
    logic [POS_W-1:0]                     base;
    logic [POS_W-1:0]                     diff;

    // Next-state: en1_q is the set of lanes firing this cycle, so it selects which bits retire.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        sign_d  = sign_q;
        first_d = first_q;
        xfer    = w_ready_q && w_valid_i;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_PRIME;
                    cnt_d   = (cfg_num_vec_i == '0) ? CNT_WIDTH'(1) : cfg_num_vec_i;
                    first_d = 1'b1;
                    mask_d  = '0;
                end
            end
            ST_PRIME: state_d = ST_WAIT;
            ST_WAIT: begin
                if (xfer) begin
                    state_d = ST_ISSUE;
                    mask_d  = w_mag_i;
                    sign_d  = w_sign_i;
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_ISSUE: begin
                first_d = 1'b0;
                for (int j = 0; j < int'(VEC_LENGTH); j++) begin
                    if (en1_q[j]) begin
                        mask_d[j] = mask_q[j] & (mask_q[j] - MAG_WIDTH'(1));
                    end
                end
                if (vec_done_q) begin
                    if (cnt_q == '0) begin
                        state_d = ST_DRAIN;
                    end else if (xfer) begin
                        mask_d = w_mag_i;
                        sign_d = w_sign_i;
                        cnt_d  = cnt_q - CNT_WIDTH'(1);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from next-cycle state and masks so every control leaves a flop.
    always_comb begin
        issue_nx  = (state_d == ST_ISSUE);
        nonempty  = '0;
        pos       = '0;
        min_pos   = '1;
        base      = '0;
        diff      = '0;
        all_clear = 1'b1;
        en1_d     = '0;
        sel1_d    = '0;
        neg_d     = '0;

        for (int j = 0; j < int'(VEC_LENGTH); j++) begin
            nonempty[j] = |mask_d[j];
            for (int b = int'(MAG_WIDTH) - 1; b >= 0; b--) begin
                if (mask_d[j][b]) begin
                    pos[j] = POS_W'(b);
                end
            end
            if (nonempty[j] && (pos[j] < min_pos)) begin
                min_pos = pos[j];
            end
        end
        any_bits = |nonempty;
        base     = (min_pos > POS_W'(3)) ? POS_W'(3) : min_pos;

        for (int j = 0; j < int'(VEC_LENGTH); j++) begin
            diff      = pos[j] - base;
            en1_d[j]  = issue_nx && nonempty[j] && (diff <= POS_W'(3));
            sel1_d[j] = en1_d[j] ? 2'(diff) : 2'd0;
            neg_d[j]  = en1_d[j] && sign_d[j];
            if (nonempty[j] &&
                !(en1_d[j] && ((mask_d[j] & (mask_d[j] - MAG_WIDTH'(1))) == '0))) begin
                all_clear = 1'b0;
            end
        end

        en2_d        = issue_nx && any_bits;
        sel2_d       = en2_d ? 2'(base) : 2'd0;
        vec_done_d   = issue_nx && all_clear;
        mac_en_d     = (state_d == ST_PRIME) || issue_nx || (state_d == ST_DRAIN);
        load_accum_d = issue_nx && first_d;
        w_ready_d    = (state_d == ST_WAIT) || (vec_done_d && (cnt_d != '0));
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            sign_q       <= '0;
            first_q      <= 1'b0;
            w_ready_q    <= 1'b0;
            mac_en_q     <= 1'b0;
            load_accum_q <= 1'b0;
            sel1_q       <= '0;
            en1_q        <= '0;
            neg_q        <= '0;
            sel2_q       <= '0;
            en2_q        <= 1'b0;
            vec_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            sign_q       <= sign_d;
            first_q      <= first_d;
            w_ready_q    <= w_ready_d;
            mac_en_q     <= mac_en_d;
            load_accum_q <= load_accum_d;
            sel1_q       <= sel1_d;
            en1_q        <= en1_d;
            neg_q        <= neg_d;
            sel2_q       <= sel2_d;
            en2_q        <= en2_d;
            vec_done_q   <= vec_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign w_ready_o       = w_ready_q;
    assign mac_en_o        = mac_en_q;
    assign load_accum_o    = load_accum_q;
    assign shift_1st_sel_o = sel1_q;
    assign shift_1st_en_o  = en1_q;
    assign is_neg_o        = neg_q;
    assign shift_2nd_sel_o = sel2_q;
    assign shift_2nd_en_o  = en2_q;
    assign vec_done_o      = vec_done_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_pragmatic_term_scheduler.sv
// Scoreboard bench: the driver pushes the expected cycle records for each accepted vector,
// the monitor pops and compares whenever the scheduler shows an active cycle.
module tb_pragmatic_term_scheduler;

    localparam int VL = 16;
    localparam int MW = 7;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                w_ready;
        logic                mac_en;
        logic                load_accum;
        logic                vec_done;
        logic                en2;
        logic [1:0]          sel2;
        logic [VL-1:0]       en1;
        logic [VL-1:0][1:0]  sel1;
        logic [VL-1:0]       neg;
    } obs_t;

    typedef struct {
        logic [VL-1:0][MW-1:0] mag;
        logic [VL-1:0]         sign;
        int                    gap;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic                  start_i;
    logic [7:0]            cfg_num_vec_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic [VL-1:0][MW-1:0] w_mag_i;
    logic [VL-1:0]         w_sign_i;
    logic                  mac_en_o;
    logic                  load_accum_o;
    logic [VL-1:0][1:0]    shift_1st_sel_o;
    logic [VL-1:0]         shift_1st_en_o;
    logic [VL-1:0]         is_neg_o;
    logic [1:0]            shift_2nd_sel_o;
    logic                  shift_2nd_en_o;
    logic                  vec_done_o;
    logic                  busy_o;
    logic                  done_o;

    obs_t exp_q[$];
    vec_t tile_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   prev_xfer  = 1'b0;

    pragmatic_term_scheduler dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .cfg_num_vec_i   (cfg_num_vec_i),
        .w_valid_i       (w_valid_i),
        .w_ready_o       (w_ready_o),
        .w_mag_i         (w_mag_i),
        .w_sign_i        (w_sign_i),
        .mac_en_o        (mac_en_o),
        .load_accum_o    (load_accum_o),
        .shift_1st_sel_o (shift_1st_sel_o),
        .shift_1st_en_o  (shift_1st_en_o),
        .is_neg_o        (is_neg_o),
        .shift_2nd_sel_o (shift_2nd_sel_o),
        .shift_2nd_en_o  (shift_2nd_en_o),
        .vec_done_o      (vec_done_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o.busy       = busy_o;
        o.done       = done_o;
        o.w_ready    = w_ready_o;
        o.mac_en     = mac_en_o;
        o.load_accum = load_accum_o;
        o.vec_done   = vec_done_o;
        o.en2        = shift_2nd_en_o;
        o.sel2       = shift_2nd_sel_o;
        o.en1        = shift_1st_en_o;
        o.sel1       = shift_1st_sel_o;
        o.neg        = is_neg_o;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every non-reset cycle is classified as active, waiting or idle.
    always @(negedge clk) begin
        obs_t act, exp;
        if (reset_i) begin
            prev_xfer = 1'b0;
        end else begin
            act = sample();
            if (act.mac_en || act.done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_active: got %h want none", act);
                end else begin
                    exp = exp_q.pop_front();
                    check("active", act, exp);
                end
            end else if (act.busy) begin
                exp = '0;
                exp.busy = 1'b1;
                exp.w_ready = 1'b1;
                check("wait", act, exp);
                check_int("no_bubble", int'(prev_xfer), 0);
            end else begin
                exp = '0;
                check("idle", act, exp);
            end
            prev_xfer = act.w_ready && w_valid_i;
        end
    end

    // Reference: retire set weight bits lowest-first with a shared base clamped to 3.
    task automatic push_vec(input logic [VL-1:0][MW-1:0] mag, input logic [VL-1:0] sign,
                            input bit first_tile, input bit last);
        int   rem[VL];
        int   low[VL];
        int   mn, base, k;
        bit   left;
        obs_t r;
        for (int j = 0; j < VL; j++) rem[j] = int'(mag[j]);
        k = 0;
        do begin
            r = '0;
            r.busy = 1'b1;
            r.mac_en = 1'b1;
            r.load_accum = first_tile && (k == 0);
            mn = MW;
            for (int j = 0; j < VL; j++) begin
                low[j] = MW;
                for (int b = MW - 1; b >= 0; b--) if (((rem[j] >> b) & 1) == 1) low[j] = b;
                if (low[j] < mn) mn = low[j];
            end
            if (mn < MW) begin
                base = (mn > 3) ? 3 : mn;
                r.en2 = 1'b1;
                r.sel2 = 2'(base);
                for (int j = 0; j < VL; j++) begin
                    if (rem[j] != 0 && low[j] - base <= 3) begin
                        r.en1[j] = 1'b1;
                        r.sel1[j] = 2'(low[j] - base);
                        r.neg[j] = sign[j];
                        rem[j] = rem[j] - (1 << low[j]);
                    end
                end
            end
            left = 1'b0;
            for (int j = 0; j < VL; j++) if (rem[j] != 0) left = 1'b1;
            r.vec_done = !left;
            r.w_ready = !left && !last;
            exp_q.push_back(r);
            k++;
        end while (left);
        if (last) begin
            r = '0;
            r.busy = 1'b1;
            r.mac_en = 1'b1;
            exp_q.push_back(r);
            r = '0;
            r.busy = 1'b1;
            r.done = 1'b1;
            exp_q.push_back(r);
        end
    endtask

    function automatic obs_t prime_rec();
        obs_t r;
        r = '0;
        r.busy = 1'b1;
        r.mac_en = 1'b1;
        return r;
    endfunction

    task automatic add_vec(input logic [VL-1:0][MW-1:0] mag, input logic [VL-1:0] sign,
                           input int gap);
        vec_t v;
        v.mag = mag;
        v.sign = sign;
        v.gap = gap;
        tile_q.push_back(v);
    endtask

    task automatic add_random_vec();
        logic [VL-1:0][MW-1:0] m;
        logic [MW-1:0]         keep;
        keep = MW'($urandom);
        for (int j = 0; j < VL; j++) m[j] = MW'($urandom) & keep;
        if ($urandom_range(0, 7) == 0) m = '0;
        add_vec(m, VL'($urandom), int'($urandom_range(0, 2)));
    endtask

    // Runs one tile from the queued vectors; caller sits just after a rising edge in IDLE.
    task automatic run_tile(input int cfg);
        int n, idx, gap, cyc;
        bit ok;
        n = (cfg == 0) ? 1 : cfg;
        start_i = 1'b1;
        cfg_num_vec_i = 8'(cfg);
        exp_q.push_back(prime_rec());
        @(posedge clk); #1;
        start_i = 1'b0;
        cfg_num_vec_i = 8'($urandom);
        idx = 0;
        gap = tile_q[0].gap;
        cyc = 0;
        while (idx < n && cyc < 500) begin
            start_i = 1'($urandom);
            if (gap > 0) begin
                w_valid_i = 1'b0;
                w_mag_i = {VL{7'($urandom)}};
                w_sign_i = VL'($urandom);
            end else begin
                w_valid_i = 1'b1;
                w_mag_i = tile_q[idx].mag;
                w_sign_i = tile_q[idx].sign;
            end
            @(negedge clk);
            if (w_valid_i && w_ready_o) begin
                push_vec(tile_q[idx].mag, tile_q[idx].sign, idx == 0, idx == n - 1);
                idx++;
                if (idx < n) gap = tile_q[idx].gap;
            end else if (w_ready_o && gap > 0) begin
                gap--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        w_valid_i = 1'b0;
        check_int("vectors_accepted", idx, n);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
        end
        @(posedge clk); #1;
        check_int("done_seen", int'(ok), 1);
        check_int("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
        tile_q.delete();
    endtask

    task automatic reset_test();
        logic [VL-1:0][MW-1:0] m;
        bit got;
        m = {VL{7'h7F}};
        start_i = 1'b1;
        cfg_num_vec_i = 8'd2;
        exp_q.push_back(prime_rec());
        @(posedge clk); #1;
        start_i = 1'b0;
        w_valid_i = 1'b1;
        w_mag_i = m;
        w_sign_i = 16'h5555;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (w_valid_i && w_ready_o) begin
                push_vec(m, 16'h5555, 1'b1, 1'b0);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        check_int("reset_test_xfer", int'(got), 1);
        w_valid_i = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        exp_q.delete();
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [VL-1:0][MW-1:0] m;
        reset_i = 1'b1;
        start_i = 1'b0;
        cfg_num_vec_i = '0;
        w_valid_i = 1'b0;
        w_mag_i = '0;
        w_sign_i = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        m = '0; m[0] = 7'h05;
        add_vec(m, 16'h0001, 0);
        run_tile(1);

        m = '0; m[0] = 7'h41; m[1] = 7'h08;
        add_vec(m, 16'h0002, 0);
        run_tile(1);

        m = '0; m[0] = 7'h01; m[1] = 7'h20;
        add_vec(m, 16'h0003, 0);
        run_tile(1);

        m = {VL{7'h7F}};
        add_vec(m, 16'hAAAA, 0);
        add_vec('0, 16'hFFFF, 0);
        run_tile(2);

        m = '0; m[3] = 7'h11; m[9] = 7'h06;
        add_vec(m, 16'h0200, 0);
        m = '0; m[2] = 7'h03;
        add_vec(m, 16'h0004, 2);
        m = '0; m[15] = 7'h50;
        add_vec(m, 16'h8000, 0);
        run_tile(3);

        m = '0; m[7] = 7'h7F;
        add_vec(m, 16'h0080, 1);
        run_tile(0);

        for (int t = 0; t < 30; t++) begin
            int cfg;
            cfg = int'($urandom_range(0, 4));
            for (int v = 0; v < ((cfg == 0) ? 1 : cfg); v++) add_random_vec();
            run_tile(cfg);
        end

        reset_test();

        add_random_vec();
        add_random_vec();
        run_tile(2);

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pragmatic_term_scheduler.md
PRAGMATIC_TERM_SCHEDULER -- requirements
Module: pragmatic_term_scheduler

Interface
REQ-001 Parameters SHALL be: VEC_LENGTH 16, lanes per weight vector; MAG_WIDTH 7, weight magnitude bits; CNT_WIDTH 8, vector-count width.
REQ-002 clk  in  1  single clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin tile; sampled only in IDLE.
REQ-005 cfg_num_vec  in  CNT_WIDTH  weight vectors per tile; 0 treated as 1; sampled with start.
REQ-006 w_valid / w_ready  in / out  1 / 1  weight-vector handshake; transfer when both high at clk edge.
REQ-007 w_mag  in  MAG_WIDTH x VEC_LENGTH  per-lane weight magnitude.
REQ-008 w_sign  in  1 x VEC_LENGTH  per-lane weight sign, 1 = negative.
REQ-009 mac_en  out  1  MAC register enable.
REQ-010 load_accum  out  1  MAC accumulator seeds from result_prev.
REQ-011 shift_1st_sel / shift_1st_en / is_neg  out  2 / 1 / 1, each x VEC_LENGTH  per-lane first-stage controls.
REQ-012 shift_2nd_sel / shift_2nd_en  out  2 / 1  shared second-stage controls.
REQ-013 vec_done  out  1  pulse on last issue cycle of each vector.
REQ-014 busy / done  out  1 / 1  state != IDLE; one-cycle tile-complete pulse.

Function
REQ-015 FSM states SHALL be IDLE, PRIME, WAIT, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start -> PRIME next cycle; latch vector count.
REQ-017 PRIME: one cycle; mac_en=1, shift_2nd_en=0, all shift_1st_en=0, load_accum=0 (zeroes MAC psum pipeline register); -> WAIT.
REQ-018 WAIT: w_ready=1, mac_en=0; on transfer, load per-lane pending mask = w_mag, latch w_sign; -> ISSUE.
REQ-019 ISSUE term selection each cycle, from registered masks: p_j = lowest set bit of lane j; base = min over non-empty lanes of p_j, clamped to 3; shift_2nd_sel=base, shift_2nd_en=1.
REQ-020 Lane j fires iff mask non-empty and p_j-base<=3: shift_1st_en[j]=1, shift_1st_sel[j]=p_j-base, is_neg[j]=latched sign; bit p_j cleared at the clock edge.
REQ-021 Non-firing lanes: shift_1st_en=0, shift_1st_sel=0, is_neg=0; weight bit p contributes at total datapath shift p+1 (fixed scale of 2).
REQ-022 All-zero vector: exactly one ISSUE cycle, all shift_1st_en=0, shift_2nd_en=0, mac_en=1.
REQ-023 ISSUE: mac_en=1 every cycle; load_accum=1 only on first ISSUE cycle of the tile.
REQ-024 Last ISSUE cycle of a vector (all masks empty after this cycle): vec_done=1; if vectors remain, w_ready=1 and a transfer stays in ISSUE (back-to-back, no bubble), else -> WAIT; if none remain -> DRAIN, w_ready=0.
REQ-025 w_ready SHALL be 0 in all other states and ISSUE cycles.
REQ-026 DRAIN: one cycle, mac_en=1, shift_2nd_en=0, all lane enables 0; -> DONE.
REQ-027 DONE: done=1 one cycle, MAC result valid this cycle; -> IDLE.
REQ-028 start while busy SHALL be ignored; w_valid outside w_ready SHALL not be consumed.
REQ-029 Issue cycles per vector SHALL be between 1 and MAG_WIDTH.

Reset
REQ-030 On reset: state IDLE; masks, signs, counters cleared; all outputs 0, including w_ready, done, busy.
REQ-031 Reset mid-operation SHALL abort the tile in the next cycle with no done pulse; in-flight vector discarded.

Verification
REQ-032 start at cycle 0, N=1, lane0 mag 5, others 0, w_valid held -> PRIME c1, WAIT c2, ISSUE c3 (sel2=0, lane0 sel1=0, load_accum=1), ISSUE c4 (sel2=2, sel1=0, vec_done), DRAIN c5, done c6.
REQ-033 lane0 mag 0x41, lane1 mag 0x08 -> cycle A: sel2=0, lane0 sel1=0, lane1 sel1=3; cycle B: sel2=3, lane0 sel1=3, lane1 disabled.
REQ-034 lane0 mag 0x01, lane1 mag 0x20 -> cycle A: lane1 waits (5>3); cycle B: sel2=3, lane1 sel1=2.
REQ-035 All 16 lanes mag 0x7F, signs alternate -> 7 ISSUE cycles, sel2=min(k,3), sel1=k-sel2 for k=0..6, is_neg follows sign; all-zero vector -> single ISSUE cycle, both enables 0.
REQ-036 N=3, w_valid low 2 cycles after vector 1 -> 2 WAIT cycles with mac_en=0, single load_accum pulse; vectors 2 to 3 back-to-back; reset during ISSUE -> IDLE next cycle, outputs 0, no done.
